// File: rtl/sr_latch_bank_if.sv
// sr_latch_bank_if: request and status signals of one latch bank; the master drives requests, the bank (slave) drives status.
interface sr_latch_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] set_in;
    logic [WIDTH-1:0] clr_in;
    logic             clear_all;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_rise;
    logic             any_set;
    logic [CNT_W-1:0] event_cnt;
    modport master (output set_in, clr_in, clear_all, input q, q_rise, any_set, event_cnt);
    modport slave  (input set_in, clr_in, clear_all, output q, q_rise, any_set, event_cnt);
endinterface

// File: rtl/sr_latch_bank.sv
// sr_latch_bank: multi-channel clocked set/reset latch bank with synchronisers and rise pulses.
// Saturating rise-event counter compiled in only when SR_LATCH_BANK_EVENT_CNT_EN is defined.
module sr_latch_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0,
    parameter int CNT_W       = 8
) (
    input logic           clk,
    input logic           reset,
    sr_latch_bank_if.slave bus
);
    logic [WIDTH-1:0] s, r, conf_v, q_d, q_q, rise_d, rise_q;
    logic             any_q;
    if (SYNC_STAGES == 0) begin : g_bypass
        assign s = bus.set_in;
        assign r = bus.clr_in;
    end else begin : g_sync
        logic [WIDTH-1:0] s_q [SYNC_STAGES];
        logic [WIDTH-1:0] r_q [SYNC_STAGES];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    s_q[i] <= '0;
                    r_q[i] <= '0;
                end
            end else begin
                s_q[0] <= bus.set_in;
                r_q[0] <= bus.clr_in;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    s_q[i] <= s_q[i-1];
                    r_q[i] <= r_q[i-1];
                end
            end
        end
        assign s = s_q[SYNC_STAGES-1];
        assign r = r_q[SYNC_STAGES-1];
    end
    // Value taken by a channel whose set and clear are both active.
    assign conf_v = (MODE == 0) ? '0 : (MODE == 1) ? '1 : (MODE == 2) ? q_q : ~q_q;
    assign q_d    = bus.clear_all ? '0 : (s & ~r) | (~s & ~r & q_q) | (s & r & conf_v);
    assign rise_d = q_d & ~q_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= '0;
            rise_q <= '0;
            any_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            rise_q <= rise_d;
            any_q  <= |q_d;
        end
    end
    assign bus.q       = q_q;
    assign bus.q_rise  = rise_q;
    assign bus.any_set = any_q;
`ifdef SR_LATCH_BANK_EVENT_CNT_EN
    localparam logic [CNT_W+5:0] CNT_MAX = {6'd0, {CNT_W{1'b1}}};
    logic [CNT_W+5:0] pop, sum;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + (CNT_W+6)'(rise_d[i]);
        sum   = {6'd0, cnt_q} + pop;
        cnt_d = bus.clear_all ? '0 : (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign bus.event_cnt = cnt_q;
`else
    assign bus.event_cnt = '0;
`endif
endmodule
